// File: rtl/byte_unstripe_ctrl_pkg.sv
// Shared types and helpers for the byte un-striping lane scheduler.
package byte_unstripe_ctrl_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 2;
  localparam int unsigned LCNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CFG_1LANE     = 2'b00,
    CFG_2LANE     = 2'b01,
    CFG_4LANE     = 2'b10,
    CFG_4LANE_ALT = 2'b11
  } lane_cfg_t;

  // Number of active lanes for a lane_cfg code; 11 aliases the 4-lane mode.
  function automatic logic [LCNT_W-1:0] lane_count(input logic [1:0] cfg);
    case (lane_cfg_t'(cfg))
      CFG_1LANE: return LCNT_W'(1);
      CFG_2LANE: return LCNT_W'(2);
      default:   return LCNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/byte_unstripe_ctrl_if.sv
// Lane FIFO and output-stream handshake bundle.
interface byte_unstripe_ctrl_if;
  import byte_unstripe_ctrl_pkg::*;

  logic [NUM_LANES-1:0] fifo_empty;
  logic [NUM_LANES-1:0] fifo_pop;
  logic [LANE_W-1:0]    lane_sel;
  logic                 out_valid;
  logic                 out_ready;

  // Scheduler side.
  modport master (
    input  fifo_empty,
    input  out_ready,
    output fifo_pop,
    output lane_sel,
    output out_valid
  );

  // FIFO / downstream side.
  modport slave (
    output fifo_empty,
    output out_ready,
    input  fifo_pop,
    input  lane_sel,
    input  out_valid
  );
endinterface

// File: rtl/byte_unstripe_ctrl_skew_timer.sv
// Counts stall cycles on an empty lane and pulses expire when the bound is hit.
module byte_unstripe_ctrl_skew_timer #(
  parameter int unsigned SKEW_MAX = 15,
  parameter int unsigned WAIT_W   = $clog2(SKEW_MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic expire_c
);

  logic [WAIT_W-1:0] wait_cnt;

  // Expire on the same edge the counter reaches SKEW_MAX.
  assign expire_c = inc & ~clr & (wait_cnt == WAIT_W'(SKEW_MAX - 1));

  // Stall counter; saturates at SKEW_MAX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (inc && (wait_cnt != WAIT_W'(SKEW_MAX))) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/byte_unstripe_ctrl.sv
// Round-robin lane pop scheduler with output backpressure and skew detection.
module byte_unstripe_ctrl
  import byte_unstripe_ctrl_pkg::*;
#(
  parameter int unsigned SKEW_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            lane_cfg,
  byte_unstripe_ctrl_if.master  bus,
  output logic                  skew_err,
  output logic [CNT_W-1:0]      byte_cnt
);

  state_t               state;
  logic [LANE_W-1:0]    ptr;
  logic [1:0]           lanes_q;
  logic [LCNT_W-1:0]    n_act;
  logic [NUM_LANES-1:0] act_mask;
  logic [NUM_LANES-1:0] other_full;
  logic [LANE_W-1:0]    ptr_nxt;
  logic                 pop_c;
  logic                 accept_c;
  logic                 stall_c;
  logic                 tmr_clr_c;
  logic                 expire_c;

  // Pop/stall decode from registered state and live FIFO/downstream flags.
  always_comb begin
    n_act      = lane_count(lanes_q);
    act_mask   = NUM_LANES'((5'd1 << n_act) - 5'd1);
    other_full = ~bus.fifo_empty & act_mask & ~(NUM_LANES'(1) << ptr);
    ptr_nxt    = LANE_W'(ptr + LANE_W'(1)) & LANE_W'(n_act - LCNT_W'(1));
    accept_c   = bus.out_valid & bus.out_ready;
    pop_c      = (state == ST_RUN) & enable & ~bus.fifo_empty[ptr] &
                 (bus.out_ready | ~bus.out_valid);
    stall_c    = (state == ST_RUN) & enable & bus.fifo_empty[ptr] & (|other_full);
    tmr_clr_c  = (state != ST_RUN) | ~enable | pop_c;
  end

  assign bus.fifo_pop = pop_c ? (NUM_LANES'(1) << ptr) : '0;

  byte_unstripe_ctrl_skew_timer #(
    .SKEW_MAX (SKEW_MAX)
  ) u_skew (
    .clk      (clk),
    .reset    (reset),
    .inc      (stall_c),
    .clr      (tmr_clr_c),
    .expire_c (expire_c)
  );

  // Controller state, lane pointer and registered output stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      lanes_q       <= 2'b00;
      bus.out_valid <= 1'b0;
      bus.lane_sel  <= '0;
      skew_err      <= 1'b0;
      byte_cnt      <= '0;
    end else begin
      if (accept_c) byte_cnt <= byte_cnt + CNT_W'(1);

      if (pop_c) begin
        bus.out_valid <= 1'b1;
        bus.lane_sel  <= ptr;
      end else if (accept_c) begin
        bus.out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          ptr <= '0;
          if (enable) begin
            lanes_q <= lane_cfg;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state <= ST_IDLE;
            ptr   <= '0;
          end else if (expire_c) begin
            state    <= ST_ERR;
            skew_err <= 1'b1;
          end else if (pop_c) begin
            ptr <= ptr_nxt;
          end
        end
        ST_ERR: begin
          if (!enable) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
